// File: rtl/rd_responder.sv
// ============================================================================
// Module      : rd_responder
// Description : Read-strobe responder. Checks address hold, returns register
//               file data after a fixed latency and flags protocol violations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_responder #(
  parameter int              AW       = 8,
  parameter int              DW       = 8,
  parameter int              DEPTH    = 16,
  parameter int              LAT      = 1,
  parameter logic [DW-1:0]   INIT_KEY = DW'(8'h5A)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          rerr,
  output logic          proto_err,
  output logic [AW-1:0] err_addr,
  output logic          busy
);

  localparam int             c_IW     = $clog2(DEPTH);
  localparam logic [AW:0]    c_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [3:0]     c_LAT_M1 = 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  function automatic logic [DW-1:0] init_word(input int idx);
    return DW'(idx) ^ INIT_KEY;
  endfunction

  logic [DW-1:0] r_mem [DEPTH];

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_rd_q;
  logic [AW-1:0] r_cap_addr;
  logic [DW-1:0] r_cap_data;
  logic          r_cap_rerr;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic          r_rerr;
  logic          r_proto_err;
  logic [AW-1:0] r_err_addr;

  state_t        w_state_nxt;
  logic [3:0]    w_cnt_nxt;
  logic          w_cap_en;
  logic          w_rvalid_nxt;
  logic [DW-1:0] w_rdata_nxt;
  logic          w_rerr_nxt;
  logic          w_proto_nxt;
  logic [AW-1:0] w_err_addr_nxt;

  logic          w_rise;
  logic          w_rd_ok;
  logic          w_wr_ok;
  logic [DW-1:0] w_rd_word;

  assign w_rise    = rd & ~r_rd_q;
  assign w_rd_ok   = ({1'b0, addr}  < c_DEPTH);
  assign w_wr_ok   = ({1'b0, waddr} < c_DEPTH);
  assign w_rd_word = w_rd_ok ? r_mem[addr[c_IW-1:0]] : '0;

  // Storage: reads in the capture path see the pre-write contents of this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= init_word(i);
      end
    end else if (wr && w_wr_ok) begin
      r_mem[waddr[c_IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cap_en       = 1'b0;
    w_rvalid_nxt   = 1'b0;
    w_rdata_nxt    = r_rdata;
    w_rerr_nxt     = 1'b0;
    w_proto_nxt    = 1'b0;
    w_err_addr_nxt = r_err_addr;

    // A new request while a transaction is in flight is reported and dropped
    if (w_rise && (r_state != S_IDLE)) begin
      w_proto_nxt    = 1'b1;
      w_err_addr_nxt = addr;
    end

    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_cap_en    = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rd && (addr == r_cap_addr)) begin
          if (LAT == 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_LAT_M1;
          end
        end else begin
          w_proto_nxt    = 1'b1;
          w_err_addr_nxt = r_cap_addr;
          w_state_nxt    = S_IDLE;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_rvalid_nxt = 1'b1;
        w_rdata_nxt  = r_cap_data;
        w_rerr_nxt   = r_cap_rerr;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rd_q      <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_data  <= '0;
      r_cap_rerr  <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rerr      <= 1'b0;
      r_proto_err <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rd_q      <= rd;
      r_rvalid    <= w_rvalid_nxt;
      r_rdata     <= w_rdata_nxt;
      r_rerr      <= w_rerr_nxt;
      r_proto_err <= w_proto_nxt;
      r_err_addr  <= w_err_addr_nxt;
      if (w_cap_en) begin
        r_cap_addr <= addr;
        r_cap_data <= w_rd_word;
        r_cap_rerr <= ~w_rd_ok;
      end
    end
  end

  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign rerr      = r_rerr;
  assign proto_err = r_proto_err;
  assign err_addr  = r_err_addr;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/rd_responder.md
Name: rd_responder

Overview:
- Target (responder) end of the single-cycle-strobe read interface driven by the team's `rd`/`addr` initiator benches.
- Detects a read request, checks the address-stability rule and returns registered read data from an internal register file after a fixed latency.
- Flags protocol violations: address changed during the hold window, or a new request while busy.
- Includes a simple write port so tests and upstream logic can load known contents.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- DEPTH, 16, number of storage words; valid addresses are 0..DEPTH-1.
- LAT, 1, cycles from the hold-check edge to the rvalid edge; legal range 1..15.
- INIT_KEY, 8'h5A, reset content key: mem[i] resets to i[DW-1:0] ^ INIT_KEY.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd  in  1  read strobe from the initiator.
- addr  in  AW  read address; must stay stable while rd is high for the hold window.
- wr  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  DW  write data.
- rvalid  out  1  one-cycle pulse: rdata and rerr are valid.
- rdata  out  DW  read data.
- rerr  out  1  out-of-range read; qualified by rvalid.
- proto_err  out  1  one-cycle pulse on a protocol violation.
- err_addr  out  AW  address captured for the most recent violating transaction.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State = IDLE; rvalid, rerr, proto_err, busy = 0; rdata = 0; err_addr = 0.
  - mem[i] = i ^ INIT_KEY.
- Rise detection: rd_q is registered rd, reset value 0. A request starts at the edge where rd = 1 and rd_q = 0.
- FSM has four states: IDLE, HOLD, WAIT, RESP.
- IDLE, on rise:
  - Capture cap_addr = addr.
  - Capture cap_data = mem[addr] if addr < DEPTH, else 0.
  - Set cap_rerr = (addr >= DEPTH).
  - Go to HOLD.
  - A write at the same edge to the same address is not visible; old data is returned.
- HOLD, one edge:
  - If rd = 1 and addr == cap_addr: go to RESP when LAT = 1, otherwise go to WAIT with cnt = LAT-1.
  - Otherwise: pulse proto_err, set err_addr = cap_addr, go to IDLE. The transaction is aborted and no rvalid is produced.
- WAIT: decrement cnt each edge; go to RESP at the edge where cnt reaches 1.
- RESP:
  - rvalid = 1 for exactly one cycle, with rdata = cap_data and rerr = cap_rerr.
  - Next edge returns to IDLE; rvalid and rerr drop to 0; rdata holds its last value.
- Timing with LAT = 1:
  - Rise sampled at edge T0.
  - Hold checked at T1.
  - rvalid high from T2 to T3.
- Rise while not IDLE (HOLD, WAIT or RESP):
  - Pulse proto_err and set err_addr = addr.
  - The request is ignored; the in-flight transaction continues.
- After the HOLD edge, rd may stay high indefinitely. Further addr changes are ignored, and no new request starts until rd falls and rises again.
- Write: when wr = 1 and waddr < DEPTH, mem[waddr] = wdata at the edge. Writes to out-of-range addresses are dropped. Writes are accepted in every state.
- proto_err is registered, one cycle per violation; two violations at consecutive edges give two consecutive pulses.
- Reset asserted mid-transaction: aborts immediately; no rvalid is produced after release.

Test Plan:
- Reset, then rd = 1 with addr = 2 held for 2 cycles -> single rvalid pulse 2 edges after the rise, rdata = 8'h58, rerr = 0, proto_err = 0.
- rd low 1 cycle, then rd = 1 with addr = 4 for 2 cycles -> rvalid, rdata = 8'h5E; the inter-request gap produces no error.
- rd = 1 with addr = 7, then addr = 9 at the HOLD edge -> proto_err single pulse, err_addr = 7, no rvalid; the next clean read of 9 returns 8'h53.
- wr = 1, waddr = 4, wdata = 8'h33, then read 4 -> rdata = 8'h33. A write of 8'hCC to 4 on the same edge as the rise -> read returns 8'h33, and the following read returns 8'hCC.
- Read addr = 20 with DEPTH = 16 -> rvalid = 1, rerr = 1, rdata = 8'h00. Rise during WAIT with LAT = 3 and addr = 5 -> proto_err, err_addr = 5, and the original response is still delivered.
- LAT = 3, rst_n pulsed low during WAIT -> all outputs 0 immediately, no rvalid afterwards, mem contents restored to i ^ 8'h5A.
